// File: rtl/tpu_rst_pkg.sv
// tpu_rst_pkg: state encoding and default timing shared by the staged reset sequencer.
package tpu_rst_pkg;
    localparam int ST_W = 3;
    typedef enum logic [ST_W-1:0] {HOLD, RELEASE, WAIT_ACK, GAP, RUN, ERROR} state_t;
    localparam int DEF_HOLD_CYC = 16;
    localparam int DEF_STAGE_GAP = 8;
    localparam int DEF_ACK_TIMEOUT = 255;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
endpackage

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: loadable saturating down-counter with zero flag, reused for hold, gap and ack timeout.
module rst_seq_cnt #(
    parameter int W = 8,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= W'(RST_VAL);
        else if (i_load) r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/rst_stage_sequencer.sv
// rst_stage_sequencer: holds all sub-domain resets, releases them in index order waiting on each ack,
// and reports ready or ack timeout; soft reset re-runs the sequence from RUN or ERROR.
module rst_stage_sequencer
    import tpu_rst_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int STAGE_GAP = DEF_STAGE_GAP,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        soft_rst_req,
    output logic                        soft_rst_ack,
    input  logic [N_STAGES-1:0]         stage_ack,
    output logic [N_STAGES-1:0]         stage_rst,
    output logic                        sys_ready,
    output logic                        timeout_err,
    output logic [$clog2(N_STAGES)-1:0] err_stage
);
    localparam int IW = $clog2(N_STAGES);
    localparam int CW = $clog2(max3(HOLD_CYC, STAGE_GAP, ACK_TIMEOUT) + 1);
    // Counter holds remaining-minus-one so the zero flag marks the last cycle of each wait
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(STAGE_GAP > 0 ? STAGE_GAP - 1 : 0);
    localparam logic [CW-1:0] ACK_LD = CW'(ACK_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST = IW'(N_STAGES - 1);

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [N_STAGES-1:0]   r_stage_rst;
    logic                  r_sys_ready;
    logic                  r_timeout_err;
    logic [IW-1:0]         r_err_stage;
    logic                  r_soft_rst_ack;
    logic                  w_ack;
    logic                  w_zero;
    logic                  w_load;
    logic                  w_dec;
    logic [CW-1:0]         w_load_val;

    assign w_ack = stage_ack[r_idx];

    always_comb begin
        w_load = r_state == RELEASE
               || (r_state == WAIT_ACK && w_ack && r_idx != LAST && STAGE_GAP > 0)
               || ((r_state == RUN || r_state == ERROR) && soft_rst_req);
        w_load_val = r_state == RELEASE ? ACK_LD : r_state == WAIT_ACK ? GAP_LD : HOLD_LD;
        w_dec = r_state == HOLD || r_state == WAIT_ACK || r_state == GAP;
    end

    rst_seq_cnt #(.W(CW), .RST_VAL(HOLD_CYC - 1)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= HOLD;
            r_idx          <= '0;
            r_stage_rst    <= '1;
            r_sys_ready    <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_err_stage    <= '0;
            r_soft_rst_ack <= 1'b0;
        end else begin
            r_soft_rst_ack <= 1'b0;
            case (r_state)
                HOLD: if (w_zero) r_state <= RELEASE;
                RELEASE: begin
                    r_stage_rst[r_idx] <= 1'b0;
                    r_state            <= WAIT_ACK;
                end
                // An ack on the expiry cycle still counts as success
                WAIT_ACK: begin
                    if (w_ack) begin
                        if (r_idx == LAST) begin
                            r_state     <= RUN;
                            r_sys_ready <= 1'b1;
                        end else if (STAGE_GAP == 0) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= RELEASE;
                        end else begin
                            r_state <= GAP;
                        end
                    end else if (w_zero) begin
                        r_state       <= ERROR;
                        r_stage_rst   <= '1;
                        r_sys_ready   <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_err_stage   <= r_idx;
                    end
                end
                GAP: begin
                    if (w_zero) begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= RELEASE;
                    end
                end
                RUN, ERROR: begin
                    if (soft_rst_req) begin
                        r_state        <= HOLD;
                        r_idx          <= '0;
                        r_stage_rst    <= '1;
                        r_sys_ready    <= 1'b0;
                        r_timeout_err  <= 1'b0;
                        r_err_stage    <= '0;
                        r_soft_rst_ack <= 1'b1;
                    end
                end
                default: r_state <= HOLD;
            endcase
        end
    end

    assign stage_rst    = r_stage_rst;
    assign sys_ready    = r_sys_ready;
    assign timeout_err  = r_timeout_err;
    assign err_stage    = r_err_stage;
    assign soft_rst_ack = r_soft_rst_ack;
endmodule
